// File: rtl/fetch_if.sv
// fetch_if: memory request/response, redirect and decoder channels of the fetch stage
interface fetch_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTRUCTION_WIDTH = 32
);
  logic mem_req_valid;
  logic mem_req_ready;
  logic [ADDRESS_WIDTH-1:0] mem_req_address;
  logic mem_resp_valid;
  logic [INSTRUCTION_WIDTH-1:0] mem_resp_data;
  logic mem_resp_error;
  logic redirect_valid;
  logic [ADDRESS_WIDTH-1:0] redirect_address;
  logic instruction_valid;
  logic instruction_ready;
  logic [INSTRUCTION_WIDTH-1:0] instruction_data;
  logic [ADDRESS_WIDTH-1:0] instruction_pc;
  logic instruction_fault;
  modport master (
    output mem_req_valid, mem_req_address, instruction_valid, instruction_data, instruction_pc, instruction_fault,
    input mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error, redirect_valid, redirect_address, instruction_ready
  );
  modport slave (
    input mem_req_valid, mem_req_address, instruction_valid, instruction_data, instruction_pc, instruction_fault,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error, redirect_valid, redirect_address, instruction_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, credit-limited word requests, in-order tag queue, output FIFO, redirect flush
module fetch_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;
  typedef enum logic {FETCH, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0] tw_q, tw_d, tr_q, tr_d, fw_q, fw_d, fr_q, fr_d;
  logic [ADDRESS_WIDTH-1:0] tag_q [DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] data_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] ipc_q [DEPTH];
  logic [DEPTH-1:0] fault_q;
  logic [SW-1:0] used;
  logic fire, take, pop, misaligned, push, push_fault;
  logic [PW-1:0] push_idx;
  logic [INSTRUCTION_WIDTH-1:0] push_data;
  logic [ADDRESS_WIDTH-1:0] push_pc;
  assign used = SW'(inflight_q) + SW'(drop_q) + SW'(cnt_q);
  // state reads FETCH while reset is held, so the request is gated by rst itself
  assign bus.mem_req_valid = rst && state_q == FETCH && !bus.redirect_valid && used < SW'(DEPTH);
  assign bus.mem_req_address = pc_q;
  assign fire = bus.mem_req_valid && bus.mem_req_ready;
  assign take = bus.mem_resp_valid && drop_q == '0 && !bus.redirect_valid;
  assign pop = bus.instruction_valid && bus.instruction_ready;
  assign misaligned = bus.redirect_address[1:0] != 2'b00;
  assign bus.instruction_valid = cnt_q != '0;
  assign bus.instruction_data = bus.instruction_valid ? data_q[fr_q] : '0;
  assign bus.instruction_pc = bus.instruction_valid ? ipc_q[fr_q] : '0;
  assign bus.instruction_fault = bus.instruction_valid && fault_q[fr_q];
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inflight_d = inflight_q;
    drop_d = drop_q;
    cnt_d = cnt_q;
    tw_d = tw_q;
    tr_d = tr_q;
    fw_d = fw_q;
    fr_d = fr_q;
    push = take;
    push_idx = fw_q;
    push_data = bus.mem_resp_error ? '0 : bus.mem_resp_data;
    push_pc = tag_q[tr_q];
    push_fault = bus.mem_resp_error;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_address;
      state_d = misaligned ? HALT : FETCH;
      // everything still owed by memory, minus a response consumed this cycle, must be discarded
      drop_d = drop_q + inflight_q - CW'(bus.mem_resp_valid);
      inflight_d = '0;
      tw_d = '0;
      tr_d = '0;
      fr_d = '0;
      fw_d = PW'(misaligned);
      cnt_d = CW'(misaligned);
      push = misaligned;
      push_idx = '0;
      push_data = '0;
      push_pc = bus.redirect_address;
      push_fault = 1'b1;
    end else begin
      pc_d = fire ? pc_q + ADDRESS_WIDTH'(4) : pc_q;
      tw_d = fire ? tw_q + PW'(1) : tw_q;
      tr_d = take ? tr_q + PW'(1) : tr_q;
      fw_d = take ? fw_q + PW'(1) : fw_q;
      fr_d = pop ? fr_q + PW'(1) : fr_q;
      drop_d = drop_q - CW'(bus.mem_resp_valid && drop_q != '0);
      inflight_d = inflight_q + CW'(fire) - CW'(take);
      cnt_d = cnt_q + CW'(take) - CW'(pop);
      state_d = take && bus.mem_resp_error ? HALT : state_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q <= '0;
      cnt_q <= '0;
      tw_q <= '0;
      tr_q <= '0;
      fw_q <= '0;
      fr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      drop_q <= drop_d;
      cnt_q <= cnt_d;
      tw_q <= tw_d;
      tr_q <= tr_d;
      fw_q <= fw_d;
      fr_q <= fr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (fire) tag_q[tw_q] <= pc_q;
    if (push) begin
      data_q[push_idx] <= push_data;
      ipc_q[push_idx] <= push_pc;
      fault_q[push_idx] <= push_fault;
    end
  end
endmodule
